// File: rtl/uart_receive_if.sv
// Output side of the audio-link UART receiver: the recovered word plus its status strobes.
// The receiver drives the master modport; the sample pipeline reads through the slave modport.
interface uart_receive_if #(
    parameter int MESSAGE_WIDTH = 16
);
    logic [MESSAGE_WIDTH-1:0] data_out;
    logic                     valid_out;
    logic                     frame_error_out;
    logic                     busy_out;

    modport master (output data_out, valid_out, frame_error_out, busy_out);
    modport slave  (input  data_out, valid_out, frame_error_out, busy_out);
endinterface

// File: rtl/uart_receive.sv
// Receive-side UART for the audio serial link: 1 start bit, MESSAGE_WIDTH data bits LSB-first, 1 stop bit.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around every sample point.
module uart_receive #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int MESSAGE_WIDTH    = 16
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           rx_wire_in,
    uart_receive_if.master out_if
);
    localparam int CYCLES_PER_BAUD = INPUT_CLOCK_FREQ / (44100 * (MESSAGE_WIDTH + 1));
    localparam int HALF_BAUD       = CYCLES_PER_BAUD / 2;
    localparam int CNT_W           = $clog2(CYCLES_PER_BAUD);
    localparam int IDX_W           = $clog2(MESSAGE_WIDTH) + 1;

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Decisions land one cycle after the nominal sample, so the counter restarts one cycle later
    // and every later decision again falls on CYCLES_PER_BAUD-1.
    localparam int START_DEC = HALF_BAUD;
    localparam int BAUD_DEC  = CYCLES_PER_BAUD - 1;

    if (CYCLES_PER_BAUD < 4) begin : g_baud_check
        $error("uart_receive: majority vote needs CYCLES_PER_BAUD >= 4");
    end
`else
    localparam int START_DEC = HALF_BAUD - 1;
    localparam int BAUD_DEC  = CYCLES_PER_BAUD - 1;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

    logic                     sync_q, rx_s_q;
    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [MESSAGE_WIDTH-1:0] shift_q, shift_d;
    logic [MESSAGE_WIDTH-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     ferr_q, ferr_d;
    logic                     busy_q, busy_d;
    logic                     sample;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] vote_q, vote_d;

    assign sample = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
`else
    assign sample = rx_s_q;
`endif

    always_comb begin
        // NOTE: every signal gets its default first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = busy_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
        vote_d  = vote_q;
        if (state_q == START) begin
            if (cnt_q == CNT_W'(START_DEC - 2)) vote_d[0] = rx_s_q;
            if (cnt_q == CNT_W'(START_DEC - 1)) vote_d[1] = rx_s_q;
        end else if (state_q == DATA || state_q == STOP) begin
            if (cnt_q == CNT_W'(BAUD_DEC - 2)) vote_d[0] = rx_s_q;
            if (cnt_q == CNT_W'(BAUD_DEC - 1)) vote_d[1] = rx_s_q;
        end
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (cnt_q == CNT_W'(START_DEC)) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (sample) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(BAUD_DEC)) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    shift_d = {sample, shift_q[MESSAGE_WIDTH-1:1]};
                    if (idx_q == IDX_W'(MESSAGE_WIDTH - 1)) state_d = STOP;
                end
            end
            STOP: begin
                // Decided mid-stop-bit so a following start edge is not missed.
                if (cnt_q == CNT_W'(BAUD_DEC)) begin
                    cnt_d = '0;
                    if (sample) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // The synchronizer flops reset to the idle line level so release never looks like a start bit.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            vote_q  <= 2'b11;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync_q  <= rx_wire_in;
            rx_s_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
            vote_q  <= vote_d;
`endif
        end
    end

    assign out_if.data_out        = data_q;
    assign out_if.valid_out       = valid_q;
    assign out_if.frame_error_out = ferr_q;
    assign out_if.busy_out        = busy_q;
endmodule

// File: tb/tb_uart_receive.sv
// Self-checking bench for uart_receive: a model transmitter pushes expected words to a scoreboard,
// and a monitor pops and compares them whenever the receiver pulses valid or frame error.
module tb_uart_receive;
    localparam int MW   = 16;
    localparam int CPB  = 133;
    localparam int HALF = 66;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE_EXTRA = 1;
`else
    localparam int VOTE_EXTRA = 0;
`endif
    // Cycles from driving the start bit on the pin to the pulse: 2 sync + T0 + stop decision + register.
    localparam int LATENCY = 3 + HALF + (MW + 1) * CPB + VOTE_EXTRA;

    typedef struct {
        bit          is_err;
        logic [15:0] data;
        int          start_cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    int   cycle_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    int   ferr_cnt = 0;
    int   valid_cyc[$];
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_pulse = 1'b0;
    logic [15:0] last_good = 16'h0000;

    uart_receive_if #(.MESSAGE_WIDTH(MW)) rx_if ();

    uart_receive #(
        .INPUT_CLOCK_FREQ(100_000_000),
        .MESSAGE_WIDTH   (MW)
    ) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .rx_wire_in(rx),
        .out_if    (rx_if.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (rx_if.valid_out || rx_if.frame_error_out)) begin
            check("pulse_overlap", 32'(rx_if.valid_out & rx_if.frame_error_out), 32'd0);
            check("pulse_twice", 32'(prev_pulse), 32'd0);
            if (rx_if.frame_error_out) ferr_cnt <= ferr_cnt + 1;
            if (rx_if.valid_out) valid_cyc.push_back(cycle_cnt);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", 32'(rx_if.frame_error_out), 32'(mon_e.is_err));
                check("pulse_data", 32'(rx_if.data_out), 32'(mon_e.data));
                check("pulse_latency", 32'(cycle_cnt - mon_e.start_cyc), 32'(LATENCY));
            end
        end
        prev_pulse <= rx_if.valid_out | rx_if.frame_error_out;
    end

    // Model transmitter; called on a falling edge and returns on one, leaving the stop level driven.
    task automatic send_frame(input logic [15:0] d, input logic stop_bit, input bit glitch);
        logic [17:0] bits;
        exp_t        e;
        bits        = {stop_bit, d, 1'b0};
        e.is_err    = !stop_bit;
        e.data      = stop_bit ? d : last_good;
        e.start_cyc = cycle_cnt;
        if (stop_bit) last_good = d;
        exp_q.push_back(e);
        for (int i = 0; i < 18; i++) begin
            for (int c = 0; c < CPB; c++) begin
                rx = (glitch && c == HALF) ? ~bits[i] : bits[i];
                @(negedge clk);
            end
        end
    endtask

    task automatic idle_drain(input string tag, input int cycles);
        rx = 1'b1;
        for (int i = 0; i < cycles && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        logic [17:0] bits;
        int          n_cycles;

        repeat (5) @(negedge clk);
        check("reset_data", 32'(rx_if.data_out), 32'd0);
        check("reset_valid", 32'(rx_if.valid_out), 32'd0);
        check("reset_ferr", 32'(rx_if.frame_error_out), 32'd0);
        check("reset_busy", 32'(rx_if.busy_out), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single frame
        send_frame(16'hA5C3, 1'b1, 1'b0);
        idle_drain("drain_a5c3", 3000);
        check("a5c3_data_hold", 32'(rx_if.data_out), 32'h0000_A5C3);
        check("a5c3_no_ferr", 32'(ferr_cnt), 32'd0);

        // Back-to-back frames with no idle gap
        valid_cyc.delete();
        send_frame(16'h0001, 1'b1, 1'b0);
        send_frame(16'hFFFF, 1'b1, 1'b0);
        idle_drain("drain_b2b", 3000);
        check("b2b_count", 32'(valid_cyc.size()), 32'd2);
        if (valid_cyc.size() >= 2)
            check("b2b_spacing", 32'(valid_cyc[1] - valid_cyc[0]), 32'(18 * CPB));
        check("b2b_data_hold", 32'(rx_if.data_out), 32'h0000_FFFF);

        // Short low glitch is rejected in START
        valid_cyc.delete();
        repeat (100) @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_high", 32'(rx_if.busy_out), 32'd1);
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (55) @(negedge clk);
        check("glitch_busy_low", 32'(rx_if.busy_out), 32'd0);
        repeat (300) @(negedge clk);
        check("glitch_no_valid", 32'(valid_cyc.size()), 32'd0);

        // Stop bit low, line stuck low
        send_frame(16'h1234, 1'b0, 1'b0);
        repeat (500) @(negedge clk);
        check("ferr_busy_stuck", 32'(rx_if.busy_out), 32'd1);
        check("ferr_count", 32'(ferr_cnt), 32'd1);
        check("ferr_data_kept", 32'(rx_if.data_out), 32'h0000_FFFF);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("ferr_busy_release", 32'(rx_if.busy_out), 32'd0);
        idle_drain("drain_ferr", 100);

        // Reset asserted during data bit 8 of 16'hBEEF
        bits = {1'b1, 16'hBEEF, 1'b0};
        for (int i = 0; i < 10; i++) begin
            n_cycles = (i < 9) ? CPB : 40;
            for (int c = 0; c < n_cycles; c++) begin
                rx = bits[i];
                @(negedge clk);
            end
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_data", 32'(rx_if.data_out), 32'd0);
        check("rst_mid_valid", 32'(rx_if.valid_out), 32'd0);
        check("rst_mid_ferr", 32'(rx_if.frame_error_out), 32'd0);
        check("rst_mid_busy", 32'(rx_if.busy_out), 32'd0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rst_n     = 1'b1;
        last_good = 16'h0000;
        valid_cyc.delete();
        repeat (20) @(negedge clk);
        check("rst_release_busy", 32'(rx_if.busy_out), 32'd0);
        send_frame(16'h00FF, 1'b1, 1'b0);
        idle_drain("drain_after_rst", 3000);
        check("after_rst_count", 32'(valid_cyc.size()), 32'd1);
        check("after_rst_data", 32'(rx_if.data_out), 32'h0000_00FF);

`ifdef UART_RX_MAJORITY_VOTE_EN
        // One-cycle inverted glitch at every nominal sample point
        send_frame(16'h5555, 1'b1, 1'b1);
        idle_drain("drain_vote", 3000);
        check("vote_data", 32'(rx_if.data_out), 32'h0000_5555);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
